seq_arithmetic: RTL and testbench

Multi-cycle, parametrised unsigned arithmetic unit that succeeds the 8-bit combinational add/subtract/shift block. It takes two WIDTH-bit operands and a mode, and computes add or subtract in one cycle. It computes full multiply (shift-add) or divide (restoring) over WIDTH cycles. Results are returned under a start/done handshake. It sits between the operand registers and the result bus of the datapath and is the single shared arithmetic resource.

---
 rtl/seq_arithmetic.sv | 138 +++++++++++++
 tb/tb_seq_arithmetic.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_arithmetic.sv
// Shared multi-cycle unsigned arithmetic unit: single-cycle add/subtract,
// WIDTH-cycle shift-add multiply and restoring divide, under a start/done handshake.
module seq_arithmetic #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [1:0]       i_mode,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result_lo,
   output logic [WIDTH-1:0] o_result_hi,
   output logic             o_carry
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [1:0]         r_mode;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_rem;
   logic               r_done;
   logic [WIDTH-1:0]   r_lo;
   logic [WIDTH-1:0]   r_hi;
   logic               r_carry;

   logic               w_accept;
   logic [WIDTH:0]     w_addsub;
   logic [WIDTH:0]     w_mul_sum;
   logic [WIDTH:0]     w_div_sh;
   logic [WIDTH-1:0]   w_div_diff;
   logic               w_div_ge;

   assign w_accept = (r_state == S_IDLE) && i_start;

   // Bit WIDTH of the extended difference is exactly the borrow (a < b).
   assign w_addsub = i_mode[0] ? ({1'b0, i_a} - {1'b0, i_b})
                               : ({1'b0, i_a} + {1'b0, i_b});

   // Multiply: low half of r_acc starts as the multiplier and drains out LSB first.
   assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);

   // Divide: r_acc low half holds the dividend shifting out MSB first, quotient shifting in.
   assign w_div_sh   = {r_rem, r_acc[WIDTH-1]};
   assign w_div_ge   = (w_div_sh >= {1'b0, r_b});
   assign w_div_diff = w_div_sh[WIDTH-1:0] - r_b;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_next = i_mode[1] ? S_CALC : S_DONE;
         S_CALC:  if (r_cnt == LAST) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_mode <= i_mode;
         r_a    <= i_a;
         r_b    <= i_b;
         r_rem  <= '0;
         if (i_mode[1]) r_acc <= {{WIDTH{1'b0}}, (i_mode[0] ? i_a : i_b)};
         else           r_acc <= {{(WIDTH-1){1'b0}}, w_addsub};
      end else if (r_state == S_CALC) begin
         if (r_mode[0]) begin
            r_rem            <= w_div_ge ? w_div_diff : w_div_sh[WIDTH-1:0];
            r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], w_div_ge};
         end else begin
            r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_lo    <= '0;
         r_hi    <= '0;
         r_carry <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= (r_state == S_DONE);
         if (w_accept)               r_cnt <= '0;
         else if (r_state == S_CALC) r_cnt <= r_cnt + CNT_W'(1);
         // Results are published together with the done pulse and held until the next one.
         if (r_state == S_DONE) begin
            case (r_mode)
               2'b10: begin
                  r_lo    <= r_acc[WIDTH-1:0];
                  r_hi    <= r_acc[2*WIDTH-1:WIDTH];
                  r_carry <= |r_acc[2*WIDTH-1:WIDTH];
               end
               2'b11: begin
                  if (r_b == '0) begin
                     r_lo    <= '1;
                     r_hi    <= r_a;
                     r_carry <= 1'b1;
                  end else begin
                     r_lo    <= r_acc[WIDTH-1:0];
                     r_hi    <= r_rem;
                     r_carry <= 1'b0;
                  end
               end
               default: begin
                  r_lo    <= r_acc[WIDTH-1:0];
                  r_hi    <= '0;
                  r_carry <= r_acc[WIDTH];
               end
            endcase
         end
      end
   end

   assign o_busy      = (r_state == S_CALC) || ((r_state == S_DONE) && r_mode[1]);
   assign o_done      = r_done;
   assign o_result_lo = r_lo;
   assign o_result_hi = r_hi;
   assign o_carry     = r_carry;

endmodule

// File: tb/tb_seq_arithmetic.sv
// Scoreboard bench for seq_arithmetic at WIDTH=8 (directed) and WIDTH=16 (random).
module tb_seq_arithmetic;

   typedef struct {
      longint lo;
      longint hi;
      longint c;
      int     lat;
      int     bsy;
      longint t0;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        st8, bz8, dn8, cy8;
   logic [1:0]  md8;
   logic [7:0]  a8, b8, lo8, hi8;
   logic        st16, bz16, dn16, cy16;
   logic [1:0]  md16;
   logic [15:0] a16, b16, lo16, hi16;

   seq_arithmetic #(.WIDTH(8)) u8 (
      .i_clk(clk), .i_reset(rst), .i_start(st8), .i_mode(md8), .i_a(a8), .i_b(b8),
      .o_busy(bz8), .o_done(dn8), .o_result_lo(lo8), .o_result_hi(hi8), .o_carry(cy8));

   seq_arithmetic #(.WIDTH(16)) u16 (
      .i_clk(clk), .i_reset(rst), .i_start(st16), .i_mode(md16), .i_a(a16), .i_b(b16),
      .o_busy(bz16), .o_done(dn16), .o_result_lo(lo16), .o_result_hi(hi16), .o_carry(cy16));

   exp_t q8[$];
   exp_t q16[$];
   int   checks = 0;
   int   errors = 0;
   int   bc8 = 0;
   int   bc16 = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: plain unsigned arithmetic on the operation's definition.
   function automatic exp_t model(input int w, input int md, input longint a, input longint b);
      exp_t   e;
      longint m = longint'(1) << w;
      e.lo = 0; e.hi = 0; e.c = 0; e.t0 = 0;
      case (md)
         0: begin e.lo = (a + b) % m; e.c = ((a + b) >= m) ? 1 : 0; end
         1: begin e.lo = (a - b + m) % m; e.c = (a < b) ? 1 : 0; end
         2: begin e.lo = (a * b) % m; e.hi = (a * b) / m; e.c = (e.hi != 0) ? 1 : 0; end
         default: begin
            if (b == 0) begin e.lo = m - 1; e.hi = a; e.c = 1; end
            else        begin e.lo = a / b; e.hi = a % b; e.c = 0; end
         end
      endcase
      e.lat = (md >= 2) ? w + 1 : 1;
      e.bsy = (md >= 2) ? w + 1 : 0;
      return e;
   endfunction

   task automatic score(input string tag, input exp_t e, input longint lo, input longint hi,
                        input longint c, input int bc);
      chk({tag, " result_lo"}, lo, e.lo);
      chk({tag, " result_hi"}, hi, e.hi);
      chk({tag, " carry"}, c, e.c);
      chk({tag, " latency"}, cyc - e.t0 - 1, longint'(e.lat));
      chk({tag, " busy cycles"}, longint'(bc), longint'(e.bsy));
   endtask

   always @(negedge clk) begin
      if (rst) bc8 = 0;
      else begin
         if (bz8) bc8++;
         if (dn8) begin
            if (q8.size() == 0) begin
               checks++; errors++;
               $display("FAIL w8 unexpected done: lo=%0d hi=%0d at cycle %0d", lo8, hi8, cyc);
            end else score("w8", q8.pop_front(), longint'(lo8), longint'(hi8), longint'(cy8), bc8);
            bc8 = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst) bc16 = 0;
      else begin
         if (bz16) bc16++;
         if (dn16) begin
            if (q16.size() == 0) begin
               checks++; errors++;
               $display("FAIL w16 unexpected done: lo=%0d hi=%0d at cycle %0d", lo16, hi16, cyc);
            end else score("w16", q16.pop_front(), longint'(lo16), longint'(hi16), longint'(cy16), bc16);
            bc16 = 0;
         end
      end
   end

   task automatic wait_idle(input int w);
      int n = 0;
      @(negedge clk);
      while (((w == 8) ? (bz8 || q8.size() != 0) : (bz16 || q16.size() != 0)) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++; errors++;
         $display("FAIL w%0d idle timeout: busy stuck or done missing", w);
      end
   endtask

   task automatic issue(input int w, input int md, input longint a, input longint b);
      exp_t e;
      wait_idle(w);
      e = model(w, md, a, b);
      e.t0 = cyc;
      if (w == 8) begin
         st8 = 1'b1; md8 = 2'(md); a8 = 8'(a); b8 = 8'(b); q8.push_back(e);
      end else begin
         st16 = 1'b1; md16 = 2'(md); a16 = 16'(a); b16 = 16'(b); q16.push_back(e);
      end
      @(negedge clk);
      st8 = 1'b0; st16 = 1'b0;
      md8 = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      md16 = 2'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
   endtask

   task automatic chk_zero8(input string nm);
      chk({nm, " result_lo"}, longint'(lo8), 0);
      chk({nm, " result_hi"}, longint'(hi8), 0);
      chk({nm, " carry"}, longint'(cy8), 0);
      chk({nm, " busy"}, longint'(bz8), 0);
      chk({nm, " done"}, longint'(dn8), 0);
   endtask

   initial begin
      exp_t   e;
      longint t;
      int     n;
      rst = 1'b1;
      st8 = 0; md8 = 0; a8 = 0; b8 = 0;
      st16 = 0; md16 = 0; a16 = 0; b16 = 0;
      repeat (3) @(negedge clk);
      chk_zero8("reset w8");
      chk("reset w16 result_lo", longint'(lo16), 0);
      chk("reset w16 result_hi", longint'(hi16), 0);
      chk("reset w16 busy", longint'(bz16), 0);
      chk("reset w16 done", longint'(dn16), 0);
      rst = 1'b0;

      issue(8, 0, 200, 100);
      issue(8, 1, 5, 7);
      issue(8, 1, 7, 5);
      issue(8, 2, 255, 255);
      issue(8, 2, 0, 128);
      issue(8, 3, 200, 7);
      issue(8, 3, 200, 0);
      issue(8, 3, 3, 9);

      // Starts during a multiply must be ignored.
      issue(8, 2, 13, 11);
      for (int i = 0; i < 4; i++) begin
         st8 = 1'b1; md8 = 2'b00; a8 = 8'($urandom); b8 = 8'($urandom);
         @(negedge clk);
      end
      st8 = 1'b0;

      // Start held high: accepted every WIDTH+2 cycles.
      wait_idle(8);
      t = cyc;
      st8 = 1'b1; md8 = 2'b10; a8 = 8'd200; b8 = 8'd3;
      for (int j = 0; j < 3; j++) begin
         e = model(8, 2, 200, 3);
         e.t0 = t + j * 10;
         q8.push_back(e);
      end
      repeat (21) @(negedge clk);
      st8 = 1'b0;

      // Reset in the middle of a divide aborts it silently.
      issue(8, 3, 200, 7);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      q8.delete();
      @(negedge clk);
      chk_zero8("abort w8");
      rst = 1'b0;
      issue(8, 0, 100, 27);

      for (int i = 0; i < 1000; i++) begin
         longint ra = longint'($urandom_range(0, 65535));
         longint rb = longint'($urandom_range(0, 65535));
         if ($urandom_range(0, 15) == 0) rb = 0;
         issue(16, int'($urandom_range(0, 3)), ra, rb);
      end

      n = 0;
      while ((q8.size() != 0 || q16.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (q8.size() != 0 || q16.size() != 0) begin
         checks++; errors++;
         $display("FAIL final drain: %0d w8 and %0d w16 results never arrived", q8.size(), q16.size());
      end
      repeat (30) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
